seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 8, meaning the pattern register width in bits (2..16).
REQ-002 SHALL have parameter RPT_W, default 4, meaning the repeat-count width in bits.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to transmit; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the transmission in progress.
REQ-007 SHALL have port pattern  input  PAT_W  bits to send; the low `length` bits are used, MSB first.
REQ-008 SHALL have port length  input  $clog2(PAT_W+1)  number of pattern bits per frame.
REQ-009 SHALL have port repeat_cnt  input  RPT_W  extra frames after the first; total frames = repeat_cnt+1.
REQ-010 SHALL have port data_out  output  1  serial bit stream, intended to drive the team's sequence detector data_in.
REQ-011 SHALL have port data_valid  output  1  data_out carries a pattern bit this cycle.
REQ-012 SHALL have port frame_start  output  1  high on the first bit of each frame.
REQ-013 SHALL have port busy  output  1  high in SEND or GAP.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final frame completes.
REQ-015 SHALL have port state_out  output  2  current FSM state code.

Function
REQ-016 SHALL implement FSM states IDLE=2'd0, SEND=2'd1, GAP=2'd2, DONE=2'd3, with state_out equal to the current state code.
REQ-017 SHALL, in IDLE when start=1 and abort=0, capture pattern, the effective length and repeat_cnt, then enter SEND on the same edge.
REQ-018 SHALL set effective length to PAT_W when length=0 or length>PAT_W; otherwise effective length = length.
REQ-019 SHALL ignore start in the SEND, GAP and DONE states; captured values SHALL NOT change mid-transmission.
REQ-020 SHALL, in SEND, drive data_out = captured pattern[idx] with data_valid=1, where idx starts at effective length-1 and decrements by 1 each cycle.
REQ-021 SHALL assert frame_start when in SEND and idx = effective length-1.
REQ-022 SHALL, after the bit at idx=0: enter GAP if the remaining repeat count is >0 (decrementing it); otherwise enter DONE.
REQ-023 SHALL hold GAP for exactly one cycle with data_out=0 and data_valid=0, then re-enter SEND with idx reloaded to effective length-1.
REQ-024 SHALL hold DONE for exactly one cycle with done=1, then enter IDLE; start in DONE is ignored.
REQ-025 SHALL, when abort=1 in SEND or GAP, enter IDLE on the next edge with no done pulse; abort takes priority over all other transitions.
REQ-026 SHALL ignore abort in IDLE and DONE; when start and abort are both 1 in IDLE, it SHALL remain in IDLE.
REQ-027 SHALL drive data_out=0 and data_valid=0 in all states other than SEND.
REQ-028 SHALL take length-1 cycles plus one final cycle per frame: total busy cycles = (repeat_cnt+1)*effective length + repeat_cnt.
REQ-029 SHALL derive all outputs combinationally from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, while reset=1, force state IDLE, idx=0, captured registers=0, and data_out=0, data_valid=0, frame_start=0, busy=0, done=0, state_out=2'd0.
REQ-031 SHALL, when reset is asserted mid-frame, abandon the frame immediately and emit no done pulse.

Verification
REQ-032 Bench SHALL cover single frame: pattern=8'h0B, length=4, repeat_cnt=0, start pulse -> data_out 1,0,1,1 on 4 consecutive valid cycles, frame_start on the first, done one cycle after the last, then IDLE.
REQ-033 Bench SHALL cover repeat: pattern=8'h05, length=3, repeat_cnt=2 -> frames 101,gap,101,gap,101 (11 busy cycles), single done pulse.
REQ-034 Bench SHALL cover length clamp: length=0 and length=15 with pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1.
REQ-035 Bench SHALL cover abort: abort on the 2nd bit of frame 1 of a repeat_cnt=3 job -> IDLE next cycle, data_valid=0, no done pulse.
REQ-036 Bench SHALL cover reset mid-GAP, plus start held high through DONE: reset -> all outputs 0 immediately; a held start SHALL NOT launch a new job until IDLE is reached.
REQ-037 Bench SHALL cover loopback: data_out wired to the sequence detector with pattern 101 -> the detector flags once per frame.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// Interface for the serial pattern transmitter.
// The job request (start, abort, pattern, length, repeat_cnt) flows from master to slave.
// The serial stream and status flow back from slave to master.
interface seq_pattern_tx_if #(
    parameter int PAT_W = 8,
    parameter int RPT_W = 4
) ();
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic [RPT_W-1:0] repeat_cnt;
    logic             data_out;
    logic             data_valid;
    logic             frame_start;
    logic             busy;
    logic             done;
    logic [1:0]       state_out;

    // The requester side: it issues jobs and observes the stream.
    modport master (
        output start, abort, pattern, length, repeat_cnt,
        input  data_out, data_valid, frame_start, busy, done, state_out
    );

    // The transmitter side.
    modport slave (
        input  start, abort, pattern, length, repeat_cnt,
        output data_out, data_valid, frame_start, busy, done, state_out
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter.
// It sends the low `length` bits of a captured pattern MSB first, repeat_cnt+1 times.
// Frames are separated by a one-cycle gap, and a one-cycle done pulse follows the last frame.
// Every output is decoded from registered state only.
module seq_pattern_tx #(
    parameter int PAT_W = 8,
    parameter int RPT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    seq_pattern_tx_if.slave   bus
);
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [RPT_W-1:0] r_rpt;
    logic [IDX_W-1:0] r_idx;

    logic [LEN_W-1:0] w_len_eff;
    logic [IDX_W-1:0] w_idx_load;
    logic [IDX_W-1:0] w_idx_top;
    logic             w_launch;
    logic             w_last_bit;
    logic             w_more;

    // A length of zero, or one beyond the register width, means "use the whole register".
    assign w_len_eff  = (bus.length == '0 || bus.length > LEN_MAX) ? LEN_MAX : bus.length;
    assign w_idx_load = IDX_W'(w_len_eff - LEN_W'(1));
    assign w_idx_top  = IDX_W'(r_len - LEN_W'(1));
    // A simultaneous abort cancels the start request.
    assign w_launch   = bus.start && !bus.abort;
    assign w_last_bit = (r_idx == '0);
    assign w_more     = (r_rpt != '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection; abort overrides everything while a job is active.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_launch) w_state_next = S_SEND;
            S_SEND: begin
                if (bus.abort)       w_state_next = S_IDLE;
                else if (w_last_bit) w_state_next = w_more ? S_GAP : S_DONE;
            end
            S_GAP:  w_state_next = bus.abort ? S_IDLE : S_SEND;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Job registers: captured once at launch, then only the bit index and remaining repeats move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat <= '0;
            r_len <= '0;
            r_rpt <= '0;
            r_idx <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_pat <= bus.pattern;
                        r_len <= w_len_eff;
                        r_rpt <= bus.repeat_cnt;
                        r_idx <= w_idx_load;
                    end
                end
                S_SEND: begin
                    if (!bus.abort) begin
                        if (!w_last_bit)  r_idx <= r_idx - IDX_W'(1);
                        else if (w_more)  r_rpt <= r_rpt - RPT_W'(1);
                    end
                end
                S_GAP:   r_idx <= w_idx_top;
                default: ;
            endcase
        end
    end

    // Output decode from the registered state and index.
    always_comb begin
        bus.data_out    = 1'b0;
        bus.data_valid  = 1'b0;
        bus.frame_start = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.state_out   = r_state;
        unique case (r_state)
            S_SEND: begin
                bus.data_out    = r_pat[r_idx];
                bus.data_valid  = 1'b1;
                bus.frame_start = (r_idx == w_idx_top);
                bus.busy        = 1'b1;
            end
            S_GAP:   bus.busy = 1'b1;
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx.
// A cycle-by-cycle expected trace is built from the frame/gap/done rules,
// then compared against the DUT on every falling edge.
module tb_seq_pattern_tx;
    localparam int PAT_W = 8;
    localparam int RPT_W = 4;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef struct packed {
        logic       dv;
        logic       dout;
        logic       fs;
        logic       busy;
        logic       done;
        logic [1:0] st;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];

    seq_pattern_tx_if #(.PAT_W(PAT_W), .RPT_W(RPT_W)) bus ();

    seq_pattern_tx #(.PAT_W(PAT_W), .RPT_W(RPT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Loopback "101" detector fed by the serial stream on valid cycles.
    logic [1:0] det_hist;
    int         det_cnt = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            det_hist <= 2'b00;
        end else if (bus.data_valid) begin
            det_hist <= {det_hist[0], bus.data_out};
            if ({det_hist, bus.data_out} == 3'b101) det_cnt <= det_cnt + 1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic rec_t mk(input logic dv, input logic dout, input logic fs, input logic [1:0] st);
        rec_t r;
        r.dv   = dv;
        r.dout = dout;
        r.fs   = fs;
        r.busy = (st == S_SEND) || (st == S_GAP);
        r.done = (st == S_DONE);
        r.st   = st;
        return r;
    endfunction

    function automatic rec_t observed();
        rec_t r;
        r.dv   = bus.data_valid;
        r.dout = bus.data_out;
        r.fs   = bus.frame_start;
        r.busy = bus.busy;
        r.done = bus.done;
        r.st   = bus.state_out;
        return r;
    endfunction

    function automatic int eff_len(input int len);
        return (len == 0 || len > PAT_W) ? PAT_W : len;
    endfunction

    // Expected trace: each frame sends its bits MSB first, frames are separated by a gap, and a done cycle follows.
    task automatic build_model(input logic [7:0] pat, input int len, input int rpt);
        int l;
        l = eff_len(len);
        exp_q.delete();
        for (int f = 0; f <= rpt; f++) begin
            for (int b = l - 1; b >= 0; b--) exp_q.push_back(mk(1'b1, pat[b], b == l - 1, S_SEND));
            if (f < rpt) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, S_GAP));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, S_DONE));
    endtask

    // abort_at: -1 none, -2 random, otherwise the trace index at which abort is raised.
    task automatic run_job(input logic [7:0] pat, input int len, input int rpt, input int abort_at,
                           input bit hold, input bit scramble, input string name);
        int n, busy_cnt, done_cnt, l;
        l = eff_len(len);
        build_model(pat, len, rpt);
        if (abort_at == -2) abort_at = $urandom_range(0, exp_q.size() - 2);
        n = exp_q.size();
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.pattern    = pat;
        bus.length     = LEN_W'(len);
        bus.repeat_cnt = RPT_W'(rpt);
        bus.abort      = 1'b0;
        bus.start      = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_value($sformatf("%s_cyc%0d", name, i), observed(), exp_q[i]);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (scramble) begin
                bus.pattern    = 8'($urandom);
                bus.length     = LEN_W'($urandom_range(0, 15));
                bus.repeat_cnt = RPT_W'($urandom);
                bus.start      = 1'($urandom_range(0, 1));
            end else if (!hold) begin
                bus.start = 1'b0;
            end
            if (i == abort_at) begin
                bus.abort = 1'b1;
                break;
            end
        end
        @(negedge clk);
        check_value($sformatf("%s_idle0", name), observed(), mk(1'b0, 1'b0, 1'b0, S_IDLE));
        if (bus.done) done_cnt++;
        bus.abort = 1'b0;
        if (hold) begin
            // start still high: the first IDLE cycle launches the same job again.
            @(negedge clk);
            check_value($sformatf("%s_relaunch", name), observed(), mk(1'b1, pat[l - 1], 1'b1, S_SEND));
        end else begin
            bus.start = 1'b0;
            @(negedge clk);
            check_value($sformatf("%s_idle1", name), observed(), mk(1'b0, 1'b0, 1'b0, S_IDLE));
            if (bus.done) done_cnt++;
        end
        check_value($sformatf("%s_dones", name), done_cnt, (abort_at >= 0) ? 0 : 1);
        if (abort_at < 0)
            check_value($sformatf("%s_busycyc", name), busy_cnt, (rpt + 1) * l + rpt);
        $display("job %s pat=%h len=%0d rpt=%0d abort_at=%0d busy=%0d", name, pat, len, rpt, abort_at, busy_cnt);
    endtask

    initial begin
        int det0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pattern    = '0;
        bus.length     = '0;
        bus.repeat_cnt = '0;
        repeat (2) @(negedge clk);
        check_value("reset_state", observed(), mk(1'b0, 1'b0, 1'b0, S_IDLE));
        reset = 1'b0;

        // Repeat job, also driven into the loopback detector.
        det0 = det_cnt;
        run_job(8'h05, 3, 2, -1, 1'b0, 1'b0, "repeat");
        check_value("loopback_detects", det_cnt - det0, 3);

        run_job(8'h0B, 4, 0, -1, 1'b0, 1'b0, "single");
        run_job(8'hA5, 0, 0, -1, 1'b0, 1'b0, "clamp_len0");
        run_job(8'hA5, 15, 0, -1, 1'b0, 1'b0, "clamp_len15");
        run_job(8'hC3, 5, 3, 1, 1'b0, 1'b0, "abort");

        // start and abort together in IDLE: stays idle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        check_value("start_abort_idle", observed(), mk(1'b0, 1'b0, 1'b0, S_IDLE));
        bus.start = 1'b0;
        bus.abort = 1'b0;
        $display("job start_with_abort stays idle");

        // start held through DONE, then reset in the relaunched job's gap.
        run_job(8'h05, 3, 1, -1, 1'b1, 1'b0, "hold");
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_value("gap_before_rst", observed(), mk(1'b0, 1'b0, 1'b0, S_GAP));
        #1 reset = 1'b1;
        #1 check_value("rst_async", observed(), mk(1'b0, 1'b0, 1'b0, S_IDLE));
        @(negedge clk);
        check_value("rst_hold", observed(), mk(1'b0, 1'b0, 1'b0, S_IDLE));
        reset = 1'b0;
        @(negedge clk);
        check_value("rst_release", observed(), mk(1'b0, 1'b0, 1'b0, S_IDLE));
        $display("job reset_mid_gap done");

        // Randomized jobs with scrambled inputs mid-job and occasional aborts.
        for (int k = 0; k < 25; k++) begin
            logic [7:0] rp;
            int rl, rr, ra;
            rp = 8'($urandom);
            rl = $urandom_range(0, 15);
            rr = $urandom_range(0, 3);
            ra = ($urandom_range(0, 3) == 0) ? -2 : -1;
            run_job(rp, rl, rr, ra, 1'b0, 1'b1, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
